mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DBITS, 32, datapath width.
REQ-002 Parameter REG_INDEX_BIT_WIDTH, 4, register-index width.
REQ-003 Parameter DMEMWORDS, 2048, data RAM depth in words (word index = addr[12:2]).
REQ-004 Parameter DMEM_INIT_FILE, "test/programs/Test2.mif", RAM initial-contents file.
REQ-005 Parameters ADDR_HEX 32'hF0000000, ADDR_LEDR 32'hF0000004, ADDR_KEY 32'hF0000010, ADDR_SW 32'hF0000014; memory-mapped IO addresses.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_aluResult  in  DBITS  memory address, or ALU result to pass through.
- ex_regData2  in  DBITS  store data.
- ex_rd  in  REG_INDEX_BIT_WIDTH  destination register.
- ex_wrReg  in  1  instruction writes a register.
- ex_wrMem  in  1  instruction is a store.
- ex_memRead  in  1  1 = result is the load data, 0 = result is ex_aluResult.
- stall  in  1  hold the stage: no store, output register frozen.
- sw  in  10  debounced switches.
- key  in  4  pushbuttons, active-low.
- mem_fwd_data  out  DBITS  combinational stage result, for forwarding.
- wb_data  out  DBITS  registered result to writeback.
- wb_rd  out  REG_INDEX_BIT_WIDTH  registered destination.
- wb_wrReg  out  1  registered register-write enable.
- hex  out  16  HEX display register.
- ledr  out  10  LED register.

Function
REQ-007 Address decode: addr[31:28]==4'hF selects IO space; any other value selects RAM.
REQ-008 RAM indexing uses addr[12:2]: bits [1:0] ignored, higher address bits wrap.
REQ-009 RAM read is combinational (asynchronous) from the current address.
REQ-010 A RAM write occurs on the rising edge when ex_wrMem=1, stall=0 and the address is in RAM space; the full 32-bit ex_regData2 is written.
REQ-011 IO reads (zero-extended to DBITS):
- HEX returns hex.
- LEDR returns ledr.
- KEY returns ~key.
- SW returns sw.
- Any other IO address returns 0.
REQ-012 IO writes occur on the rising edge when ex_wrMem=1 and stall=0:
- HEX takes ex_regData2[15:0].
- LEDR takes ex_regData2[9:0].
- Writes to KEY, SW or unmapped IO addresses are ignored.
REQ-013 Load data path: mem_fwd_data = load data when ex_memRead=1, else ex_aluResult; purely combinational.
REQ-014 Output register:
- When stall=0, each rising edge loads wb_data<=mem_fwd_data, wb_rd<=ex_rd, wb_wrReg<=ex_wrReg.
- When stall=1, all three hold their values.
REQ-015 Latency: a stage input presented before edge N is visible on wb_* after edge N; loads and ALU pass-through have identical one-cycle latency.
REQ-016 Store followed by a load of the same address in the next cycle returns the new data.
REQ-017 ex_wrMem and ex_memRead both 1 is illegal. The read returns pre-write data and the write still occurs.
REQ-018 A store updates no register: wb_wrReg follows ex_wrReg only; the stage does not gate it.
REQ-019 stall asserted during a store: no write occurs until the cycle stall is 0 with ex_wrMem still asserted.

Reset
REQ-020 While reset=1:
- wb_data=0, wb_rd=0, wb_wrReg=0, hex=0, ledr=0, immediately and asynchronously.
- Stores are suppressed.
REQ-021 RAM contents are not cleared by reset; they hold DMEM_INIT_FILE values at configuration and retain written values across reset.
REQ-022 Reset asserted mid-store: the write is not guaranteed and has no effect on any register other than the RAM word addressed.
REQ-023 The first rising edge after reset deasserts resumes normal operation per REQ-014.

Verification
REQ-024 Store then load: store 32'hDEADBEEF to 0x100, then load 0x100 next cycle -> mem_fwd_data=32'hDEADBEEF; wb_data=32'hDEADBEEF one edge later.
REQ-025 RAM wrap: store 32'h12345678 to 0x2100, load 0x0100 -> 32'h12345678; load 0x0102 -> same value.
REQ-026 IO writes: store 32'hABCD1234 to ADDR_HEX and 32'hFFFFFFFF to ADDR_LEDR -> hex=16'h1234, ledr=10'h3FF; load ADDR_HEX -> 32'h00001234.
REQ-027 IO reads:
- key=4'b1010 -> load ADDR_KEY = 32'h5.
- sw=10'h2A5 -> load ADDR_SW = 32'h2A5.
- Load 0xF0000008 -> 0.
REQ-028 Stall: store 32'h55 to 0x40 with stall=1 for 3 cycles -> RAM[0x40] and wb_* unchanged; stall=0 -> write occurs and wb_* update on that edge.
REQ-029 Async reset: with hex=16'h1234 and wb_wrReg=1, pulse reset between edges -> hex=0, wb_wrReg=0 before the next edge; RAM[0x100] still 32'hDEADBEEF.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline memory stage: address decode, word RAM, memory-mapped HEX/LEDR/KEY/SW.
// Produces a combinational forwarding result and registers it toward writeback.
module mem_stage #(
  parameter int          DBITS               = 32,
  parameter int          REG_INDEX_BIT_WIDTH = 4,
  parameter int          DMEMWORDS           = 2048,
  parameter              DMEM_INIT_FILE      = "test/programs/Test2.mif",
  parameter logic [31:0] ADDR_HEX            = 32'hF0000000,
  parameter logic [31:0] ADDR_LEDR           = 32'hF0000004,
  parameter logic [31:0] ADDR_KEY            = 32'hF0000010,
  parameter logic [31:0] ADDR_SW             = 32'hF0000014
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DBITS-1:0]               ex_aluResult,
  input  logic [DBITS-1:0]               ex_regData2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  input  logic                           ex_wrReg,
  input  logic                           ex_wrMem,
  input  logic                           ex_memRead,
  input  logic                           stall,
  input  logic [9:0]                     sw,
  input  logic [3:0]                     key,
  output logic [DBITS-1:0]               mem_fwd_data,
  output logic [DBITS-1:0]               wb_data,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd,
  output logic                           wb_wrReg,
  output logic [15:0]                    hex,
  output logic [9:0]                     ledr
);

  localparam int IDXW = $clog2(DMEMWORDS);
  // The init file is applied by the device configuration flow, not by this logic.
  localparam int unused_init_len = $bits(DMEM_INIT_FILE);

  logic [DBITS-1:0]               r_mem [DMEMWORDS];
  logic [15:0]                    r_hex;
  logic [9:0]                     r_ledr;
  logic [DBITS-1:0]               r_wb_data;
  logic [REG_INDEX_BIT_WIDTH-1:0] r_wb_rd;
  logic                           r_wb_wrReg;

  logic            w_is_io;
  logic [IDXW-1:0] w_idx;
  logic [DBITS-1:0] w_ram_rdata;
  logic [DBITS-1:0] w_io_rdata;
  logic [DBITS-1:0] w_load_data;
  logic            w_store;

  assign w_is_io     = (ex_aluResult[DBITS-1 -: 4] == 4'hF);
  assign w_idx       = ex_aluResult[IDXW+1:2];
  assign w_ram_rdata = r_mem[w_idx];
  assign w_store     = ex_wrMem & ~stall & ~reset;

  always_comb begin
    w_io_rdata = '0;
    if (ex_aluResult == ADDR_HEX)
      w_io_rdata = {{(DBITS-16){1'b0}}, r_hex};
    else if (ex_aluResult == ADDR_LEDR)
      w_io_rdata = {{(DBITS-10){1'b0}}, r_ledr};
    else if (ex_aluResult == ADDR_KEY)
      w_io_rdata = {{(DBITS-4){1'b0}}, ~key};
    else if (ex_aluResult == ADDR_SW)
      w_io_rdata = {{(DBITS-10){1'b0}}, sw};
  end

  assign w_load_data  = w_is_io ? w_io_rdata : w_ram_rdata;
  assign mem_fwd_data = ex_memRead ? w_load_data : ex_aluResult;

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_store && !w_is_io)
      r_mem[w_idx] <= ex_regData2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex  <= '0;
      r_ledr <= '0;
    end else if (w_store && w_is_io) begin
      if (ex_aluResult == ADDR_HEX)
        r_hex <= ex_regData2[15:0];
      else if (ex_aluResult == ADDR_LEDR)
        r_ledr <= ex_regData2[9:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_wrReg <= 1'b0;
    end else if (!stall) begin
      r_wb_data  <= mem_fwd_data;
      r_wb_rd    <= ex_rd;
      r_wb_wrReg <= ex_wrReg;
    end
  end

  assign wb_data  = r_wb_data;
  assign wb_rd    = r_wb_rd;
  assign wb_wrReg = r_wb_wrReg;
  assign hex      = r_hex;
  assign ledr     = r_ledr;

endmodule
